// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-256 round register/round-logic pair.
// Takes one block at a time, runs NUM_ROUNDS internal writes, then holds the result until it is taken.
module aes_round_ctrl #(
   parameter int NUM_ROUNDS = 14,
   parameter int DATA_W     = 128,
   parameter int KIDX_W     = 4
) (
   input  logic              inClk,
   input  logic              inRstN,
   input  logic              inBlkValid,
   output logic              outBlkReady,
   input  logic [DATA_W-1:0] inBlkData,
   input  logic              inAbort,
   output logic              outRegExtWr,
   output logic [DATA_W-1:0] outRegExtData,
   output logic              outRegIntWr,
   input  logic [DATA_W-1:0] inRegData,
   output logic [KIDX_W-1:0] outKeyIdx,
   output logic              outLastRound,
   output logic              outResValid,
   input  logic              inResReady,
   output logic [DATA_W-1:0] outResData,
   output logic              outBusy
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_ROUND = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;

   localparam logic [KIDX_W-1:0] RND_LAST = KIDX_W'(NUM_ROUNDS);
   localparam logic [KIDX_W-1:0] RND_ONE  = KIDX_W'(1);
   localparam logic [KIDX_W-1:0] RND_ZERO = KIDX_W'(0);

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [KIDX_W-1:0] rnd_r;
   logic [KIDX_W-1:0] rnd_nxt_s;

   logic              blk_ready_s;
   logic              ext_wr_s;
   logic [DATA_W-1:0] ext_data_s;
   logic              int_wr_s;
   logic [KIDX_W-1:0] key_idx_s;
   logic              last_round_s;
   logic              res_valid_s;
   logic [DATA_W-1:0] res_data_s;
   logic              busy_s;

   // State and round-counter register
   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         state_r <= ST_IDLE;
         rnd_r   <= RND_ZERO;
      end else begin
         state_r <= state_nxt_s;
         rnd_r   <= rnd_nxt_s;
      end
   end

   // Next-state and next-round logic; abort outranks every other transition
   always_comb begin
      state_nxt_s = state_r;
      rnd_nxt_s   = rnd_r;
      case (state_r)
         ST_IDLE: begin
            if (inBlkValid && !inAbort) begin
               state_nxt_s = ST_ROUND;
               rnd_nxt_s   = RND_ONE;
            end else begin
               state_nxt_s = ST_IDLE;
               rnd_nxt_s   = RND_ZERO;
            end
         end
         ST_ROUND: begin
            if (inAbort) begin
               state_nxt_s = ST_IDLE;
               rnd_nxt_s   = RND_ZERO;
            end else if (rnd_r >= RND_LAST) begin
               // Saturating compare keeps the counter from ever passing the last round
               state_nxt_s = ST_DONE;
               rnd_nxt_s   = RND_ZERO;
            end else begin
               state_nxt_s = ST_ROUND;
               rnd_nxt_s   = rnd_r + RND_ONE;
            end
         end
         ST_DONE: begin
            if (inAbort || inResReady) begin
               state_nxt_s = ST_IDLE;
               rnd_nxt_s   = RND_ZERO;
            end else begin
               state_nxt_s = ST_DONE;
               rnd_nxt_s   = RND_ZERO;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            rnd_nxt_s   = RND_ZERO;
         end
      endcase
   end

   // Per-state output decode, before reset gating
   always_comb begin
      blk_ready_s  = 1'b0;
      ext_wr_s     = 1'b0;
      ext_data_s   = '0;
      int_wr_s     = 1'b0;
      key_idx_s    = RND_ZERO;
      last_round_s = 1'b0;
      res_valid_s  = 1'b0;
      res_data_s   = '0;
      busy_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            blk_ready_s = !inAbort;
            ext_wr_s    = inBlkValid;
            ext_data_s  = inBlkData;
         end
         ST_ROUND: begin
            int_wr_s     = 1'b1;
            key_idx_s    = rnd_r;
            last_round_s = (rnd_r == RND_LAST);
            busy_s       = 1'b1;
         end
         ST_DONE: begin
            res_valid_s = 1'b1;
            res_data_s  = inRegData;
            busy_s      = 1'b1;
         end
         default: begin
            blk_ready_s = 1'b0;
         end
      endcase
   end

   // Every output is forced low while reset is asserted, independent of the clock
   always_comb begin
      if (inRstN) begin
         outBlkReady   = blk_ready_s;
         outRegExtWr   = ext_wr_s;
         outRegExtData = ext_data_s;
         outRegIntWr   = int_wr_s;
         outKeyIdx     = key_idx_s;
         outLastRound  = last_round_s;
         outResValid   = res_valid_s;
         outResData    = res_data_s;
         outBusy       = busy_s;
      end else begin
         outBlkReady   = 1'b0;
         outRegExtWr   = 1'b0;
         outRegExtData = '0;
         outRegIntWr   = 1'b0;
         outKeyIdx     = RND_ZERO;
         outLastRound  = 1'b0;
         outResValid   = 1'b0;
         outResData    = '0;
         outBusy       = 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed plus randomized bench for aes_round_ctrl against a phase-number reference model.
// A stand-in round register is modelled so that result hold/stability is observable.
module tb_aes_round_ctrl;
   localparam int N  = 14;
   localparam int DW = 128;
   localparam int KW = 4;

   logic          inClk = 1'b0;
   logic          inRstN;
   logic          inBlkValid;
   logic [DW-1:0] inBlkData;
   logic          inAbort;
   logic          inResReady;
   logic [DW-1:0] inRegData;
   logic          outBlkReady;
   logic          outRegExtWr;
   logic [DW-1:0] outRegExtData;
   logic          outRegIntWr;
   logic [KW-1:0] outKeyIdx;
   logic          outLastRound;
   logic          outResValid;
   logic [DW-1:0] outResData;
   logic          outBusy;

   int            n_vec = 0;
   int            n_err = 0;
   int            phase = 0;      // 0 idle, 1..N round number in progress, N+1 result waiting
   int            cyc   = 0;
   int            acc_q[$];
   logic [DW-1:0] fake_reg = '0;
   logic [DW-1:0] held;

   always #5 inClk = ~inClk;
   assign inRegData = fake_reg;

   aes_round_ctrl #(.NUM_ROUNDS(N), .DATA_W(DW), .KIDX_W(KW)) dut (
      .inClk(inClk), .inRstN(inRstN), .inBlkValid(inBlkValid), .outBlkReady(outBlkReady),
      .inBlkData(inBlkData), .inAbort(inAbort), .outRegExtWr(outRegExtWr),
      .outRegExtData(outRegExtData), .outRegIntWr(outRegIntWr), .inRegData(inRegData),
      .outKeyIdx(outKeyIdx), .outLastRound(outLastRound), .outResValid(outResValid),
      .inResReady(inResReady), .outResData(outResData), .outBusy(outBusy)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check_outputs();
      logic en;
      logic idle;
      logic in_rnd;
      logic done;
      en     = inRstN;
      idle   = (phase == 0);
      in_rnd = (phase >= 1) && (phase <= N);
      done   = (phase == N + 1);
      chk("blk_ready",  DW'(outBlkReady),   DW'(en & idle & !inAbort));
      chk("ext_wr",     DW'(outRegExtWr),   DW'(en & idle & inBlkValid));
      chk("ext_data",   outRegExtData,      (en && idle) ? inBlkData : '0);
      chk("int_wr",     DW'(outRegIntWr),   DW'(en & in_rnd));
      chk("key_idx",    DW'(outKeyIdx),     (en && in_rnd) ? DW'(phase) : '0);
      chk("last_round", DW'(outLastRound),  DW'(en && (phase == N)));
      chk("res_valid",  DW'(outResValid),   DW'(en & done));
      chk("res_data",   outResData,         (en && done) ? inRegData : '0);
      chk("busy",       DW'(outBusy),       DW'(en && (phase != 0)));
   endtask

   // One clock: drive, check, advance the model at the edge
   task automatic step(input logic v, input logic [DW-1:0] d, input logic ab, input logic rr);
      int p;
      inBlkValid = v;
      inBlkData  = d;
      inAbort    = ab;
      inResReady = rr;
      #1;
      check_outputs();
      if (inRstN && outBlkReady && inBlkValid) acc_q.push_back(cyc);
      @(posedge inClk);
      p = phase;
      if (!inRstN) begin
         phase = 0;
      end else if (p == 0) begin
         if (v) fake_reg = d;
         if (v && !ab) phase = 1;
      end else if (p <= N) begin
         fake_reg = {fake_reg[DW-9:0], fake_reg[DW-1:DW-8]} + DW'(p);
         phase    = ab ? 0 : p + 1;
      end else begin
         phase = (ab || rr) ? 0 : p;
      end
      cyc++;
      #1;
   endtask

   task automatic run_to_phase(input int target, input logic rr);
      for (int i = 0; i < 40 && phase != target; i++) step(1'b0, rnd_data(), 1'b0, rr);
      chk("reach_phase", DW'(phase), DW'(target));
   endtask

   initial begin
      inRstN     = 1'b0;
      inBlkValid = 1'b1;
      inBlkData  = rnd_data();
      inAbort    = 1'b0;
      inResReady = 1'b0;
      #2;
      check_outputs();
      step(1'b1, rnd_data(), 1'b0, 1'b0);
      step(1'b1, rnd_data(), 1'b0, 1'b1);
      inRstN = 1'b1;
      step(1'b0, rnd_data(), 1'b0, 1'b1);
      chk("ready_after_reset", DW'(outBlkReady), DW'(1'b1));

      // Single block with the reference vector
      step(1'b1, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1);
      run_to_phase(N + 1, 1'b1);
      step(1'b0, rnd_data(), 1'b0, 1'b1);
      chk("single_done_idle", DW'(phase), DW'(0));

      // Backpressure in DONE while a new block is offered
      step(1'b1, rnd_data(), 1'b0, 1'b0);
      run_to_phase(N + 1, 1'b0);
      held = outResData;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, rnd_data(), 1'b0, 1'b0);
         chk("hold_data", outResData, held);
      end
      step(1'b0, rnd_data(), 1'b0, 1'b1);

      // Back-to-back with valid held high
      acc_q.delete();
      for (int i = 0; i < 40; i++) step(1'b1, rnd_data(), 1'b0, 1'b1);
      chk("b2b_accepts", DW'(acc_q.size() >= 2), DW'(1'b1));
      if (acc_q.size() >= 2) chk("b2b_gap", DW'(acc_q[1] - acc_q[0]), DW'(N + 2));
      run_to_phase(0, 1'b1);

      // Abort in IDLE, then mid-ROUND at index 7
      step(1'b1, rnd_data(), 1'b1, 1'b1);
      step(1'b1, rnd_data(), 1'b0, 1'b1);
      run_to_phase(7, 1'b1);
      step(1'b0, rnd_data(), 1'b1, 1'b1);
      chk("abort_idle", DW'(phase), DW'(0));
      step(1'b0, rnd_data(), 1'b0, 1'b0);
      step(1'b1, rnd_data(), 1'b0, 1'b1);
      chk("restart_idx", DW'(outKeyIdx), DW'(1));
      run_to_phase(N + 1, 1'b1);
      step(1'b0, rnd_data(), 1'b0, 1'b1);

      // Asynchronous reset at index 9
      step(1'b1, rnd_data(), 1'b0, 1'b1);
      run_to_phase(9, 1'b1);
      inRstN = 1'b0;
      #1;
      check_outputs();
      step(1'b0, rnd_data(), 1'b0, 1'b1);
      inRstN = 1'b1;
      step(1'b0, rnd_data(), 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         step(1'(($urandom() & 32'd1) != 32'd0), rnd_data(),
              1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
